// File: rtl/forest_sample_feeder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | forest_sample_feeder: 3-beat raw stream -> saturated 36-bit forest word,  |
// | waits out the forest latency, returns the vote on a result port. Rev 1.0  |
// +---------------------------------------------------------------------------+
module forest_sample_feeder #(
  parameter int FEAT_W  = 12,
  parameter int RAW_W   = 16,
  parameter int LATENCY = 8
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [RAW_W-1:0]    i_in_data,
  input  logic                i_in_last,
  output logic [3*FEAT_W-1:0] o_feat_out,
  input  logic [1:0]          i_class_in,
  output logic                o_res_valid,
  input  logic                i_res_ready,
  output logic [1:0]          o_res_class,
  output logic                o_res_sat,
  output logic [7:0]          o_res_seq,
  output logic                o_err_frame
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DROP    = 2'd1,
    S_WAIT    = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]          r_idx;
  logic [FEAT_W-1:0]   r_dur;
  logic [FEAT_W-1:0]   r_sbytes;
  logic                r_sat_acc;
  logic                r_pend_sat;
  logic [3*FEAT_W-1:0] r_feat;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_res_class;
  logic                r_res_sat;
  logic [7:0]          r_res_seq;
  logic                r_err;

  logic                w_accept;
  logic                w_over;
  logic [FEAT_W-1:0]   w_field;
  logic                w_commit;
  logic                w_err;
  logic                w_cnt_done;
  logic                w_res_hs;

  generate
    if (RAW_W > FEAT_W) begin : g_sat_hi
      assign w_over = |i_in_data[RAW_W-1:FEAT_W];
    end else begin : g_sat_none
      assign w_over = 1'b0;
    end
  endgenerate

  assign w_field     = w_over ? {FEAT_W{1'b1}} : i_in_data[FEAT_W-1:0];
  assign o_in_ready  = (r_state == S_COLLECT) || (r_state == S_DROP);
  assign o_res_valid = (r_state == S_RESULT);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_res_hs    = o_res_valid && i_res_ready;
  assign w_cnt_done  = (r_cnt == C_CNT_LAST);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) r_state <= S_COLLECT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          if (r_idx == 2'd2) begin
            if (i_in_last) begin
              w_commit    = 1'b1;
              w_state_nxt = S_WAIT;
            end else begin
              w_state_nxt = S_DROP;
            end
          end else if (i_in_last) begin
            w_err = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (w_accept && i_in_last) begin
          w_err       = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_WAIT:   if (w_cnt_done) w_state_nxt = S_RESULT;
      S_RESULT: if (w_res_hs)   w_state_nxt = S_COLLECT;
      default:  w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_idx       <= 2'd0;
      r_dur       <= '0;
      r_sbytes    <= '0;
      r_sat_acc   <= 1'b0;
      r_pend_sat  <= 1'b0;
      r_feat      <= '0;
      r_cnt       <= '0;
      r_res_class <= 2'd0;
      r_res_sat   <= 1'b0;
      r_res_seq   <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_err;
      // Index restarts on any in_last or after beat2, good or bad.
      if (w_accept && (r_state == S_COLLECT)) begin
        r_idx <= (i_in_last || (r_idx == 2'd2)) ? 2'd0 : r_idx + 2'd1;
        case (r_idx)
          2'd0: begin
            r_dur     <= w_field;
            r_sat_acc <= w_over;
          end
          2'd1: begin
            r_sbytes  <= w_field;
            r_sat_acc <= r_sat_acc | w_over;
          end
          default: ;
        endcase
      end
      if (w_commit) begin
        r_feat     <= {w_field, r_sbytes, r_dur};
        r_pend_sat <= r_sat_acc | w_over;
      end
      if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
        if (w_cnt_done) begin
          r_res_class <= i_class_in;
          r_res_sat   <= r_pend_sat;
        end
      end
      if (w_res_hs) r_res_seq <= r_res_seq + 8'd1;
    end
  end

  assign o_feat_out  = r_feat;
  assign o_res_class = r_res_class;
  assign o_res_sat   = r_res_sat;
  assign o_res_seq   = r_res_seq;
  assign o_err_frame = r_err;

endmodule
`default_nettype wire
